// File: rtl/tx_module.sv
// UART transmitter: one start bit, 1-8 data bits LSB first, one stop bit.
// Every serial bit spans exactly 16 pulses of the 16x baud Tick enable.
module tx_module (
  input  logic       clk,
  input  logic       rst,
  input  logic       Tick,
  input  logic       tx_start,
  input  logic [7:0] TxD,
  input  logic [3:0] N_bits,
  output logic       Tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     r_state,    w_state_next;
  logic [7:0] r_shift,    w_shift_next;
  logic [3:0] r_tick_cnt, w_tick_cnt_next;
  logic [3:0] r_bit_cnt,  w_bit_cnt_next;
  logic [3:0] r_n,        w_n_next;
  logic       r_tx,       w_tx_next;
  logic       r_busy,     w_busy_next;
  logic       r_done,     w_done_next;
  logic       w_tick_wrap;
  logic [3:0] w_bit_cnt_inc;

  assign w_tick_wrap   = Tick && (r_tick_cnt == 4'd15);
  assign w_bit_cnt_inc = r_bit_cnt + 4'd1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_n_next        = r_n;
    w_done_next     = 1'b0;

    case (r_state)
      IDLE: begin
        if (tx_start) begin
          w_shift_next    = TxD;
          w_n_next        = (N_bits == 4'd0 || N_bits > 4'd8) ? 4'd8 : N_bits;
          w_tick_cnt_next = 4'd0;
          w_bit_cnt_next  = 4'd0;
          w_state_next    = START;
        end
      end
      START: begin
        if (Tick) begin
          w_tick_cnt_next = r_tick_cnt + 4'd1;
          if (w_tick_wrap) w_state_next = DATA;
        end
      end
      DATA: begin
        if (Tick) begin
          w_tick_cnt_next = r_tick_cnt + 4'd1;
          if (w_tick_wrap) begin
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_bit_cnt_next = w_bit_cnt_inc;
            if (w_bit_cnt_inc == r_n) w_state_next = STOP;
          end
        end
      end
      STOP: begin
        if (Tick) begin
          w_tick_cnt_next = r_tick_cnt + 4'd1;
          if (w_tick_wrap) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Line level is decoded from the next state so Tx is a plain flop with no input path.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shift    <= 8'd0;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 4'd0;
      r_n        <= 4'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_n        <= w_n_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign Tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_tx_module.sv
// Self-checking bench for tx_module: a tick-count frame model compared every cycle,
// a mid-bit loopback decoder, directed frames with literal expectations, then random traffic.
module tb_tx_module;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] TxD = 8'd0;
  logic [3:0] N_bits = 4'd0;
  logic       Tx, busy, done;

  tx_module dut (
    .clk(clk), .rst(rst), .Tick(Tick), .tx_start(tx_start),
    .TxD(TxD), .N_bits(N_bits), .Tx(Tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Tick source: period in clocks, or 0 for random pulses.
  int tick_period = 4;
  int phase = 0;
  always @(posedge clk) begin
    #1;
    if (tick_period == 0) Tick = ($urandom_range(0, 2) == 0);
    else begin
      phase = (phase + 1) % tick_period;
      Tick  = (phase == 0);
    end
  end

  // Behavioural model: a frame is the bit list {0, data[0..n-1], 1}, each held for
  // 16 Ticks; m_cnt is the number of Ticks counted since acceptance.
  logic       m_busy = 1'b0, m_tx = 1'b1, m_done = 1'b0, m_adv = 1'b0;
  int         m_cnt = 0, m_n = 8;
  logic [7:0] m_data = 8'd0;
  logic [7:0] exp_q[$];
  logic       samp[$];

  function automatic logic frame_bit(input int k);
    if (k == 0) return 1'b0;
    if (k <= m_n) return m_data[k-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_tx = 1'b1; m_done = 1'b0; m_adv = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      m_adv  = 1'b0;
      if (!m_busy) begin
        if (tx_start) begin
          m_busy = 1'b1;
          m_data = TxD;
          m_n    = (N_bits >= 4'd1 && N_bits <= 4'd8) ? int'(N_bits) : 8;
          m_cnt  = 0;
          exp_q.push_back(m_data & 8'((1 << m_n) - 1));
          samp.delete();
        end
      end else if (Tick) begin
        m_cnt++;
        m_adv = 1'b1;
        if (m_cnt == (m_n + 2) * 16) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
      m_tx = m_busy ? frame_bit(m_cnt / 16) : 1'b1;
    end
  end

  int tick_total = 0;
  always @(posedge clk) if (Tick) tick_total++;

  // Compare process plus loopback decoder sampling the DUT line at mid-bit.
  logic [7:0] rx_q[$];
  logic       last_samp[$];
  logic [7:0] rx_b;
  int         k_bit;
  int         busy_run = 0, last_len = 0;
  int         done_cnt = 0, tick_at_done = 0, last_gap = 0;

  always @(negedge clk) begin
    check("tx", Tx, m_tx);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    if (!rst) samp.delete();
    else if (m_busy && m_adv && (m_cnt % 16) == 8) begin
      k_bit = m_cnt / 16;
      samp.push_back(Tx);
      if (k_bit == m_n + 1) begin
        rx_b = 8'd0;
        for (int i = 0; i < m_n; i++) rx_b[i] = samp[i+1];
        rx_q.push_back(rx_b);
        last_samp = samp;
      end
    end
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_len = busy_run;
      busy_run = 0;
    end
    if (done) begin
      done_cnt++;
      last_gap     = tick_total - tick_at_done;
      tick_at_done = tick_total;
    end
  end

  function automatic logic [31:0] pack_samp();
    logic [31:0] r = 32'd0;
    foreach (last_samp[i]) r[i] = last_samp[i];
    return r;
  endfunction

  task automatic send(input logic [7:0] d, input logic [3:0] nb, input bit sync_tick);
    int g = 0;
    @(posedge clk); #2;
    if (sync_tick) while (!Tick && g < 100) begin @(posedge clk); #2; g++; end
    TxD = d; N_bits = nb; tx_start = 1'b1;
    @(posedge clk); #2;
    tx_start = 1'b0;
    TxD = 8'($urandom);
    N_bits = 4'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int start = done_cnt;
    int g = 0;
    while (done_cnt == start && g < limit) begin @(negedge clk); g++; end
    check("done_timeout", done_cnt != start, 1);
  endtask

  task automatic expect_rx(input logic [7:0] exp);
    check("rx_count", rx_q.size() != 0, 1);
    if (rx_q.size() != 0) check("rx_byte", rx_q.pop_front(), exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, g;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", Tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #3 rst = 1'b1;
    repeat (20) @(posedge clk);
    check("idle_busy", busy, 0);

    // Basic byte, acceptance coincident with a Tick (that Tick is discarded).
    send(8'h53, 4'd8, 1'b1);
    wait_done(2000);
    @(negedge clk);
    check("basic_len", last_len, 640);
    check("basic_nsamp", last_samp.size(), 10);
    check("basic_bits", pack_samp(), 32'b1010100110);
    check("basic_done_cnt", done_cnt, 1);
    expect_rx(8'h53);

    // Short frame: 5 data bits, 112 Ticks.
    send(8'hFF, 4'd5, 1'b1);
    wait_done(2000);
    @(negedge clk);
    check("short_len", last_len, 448);
    check("short_nsamp", last_samp.size(), 7);
    check("short_bits", pack_samp(), 32'b1111110);
    expect_rx(8'h1F);

    // Out-of-range counts behave as 8 data bits.
    send(8'h01, 4'd0, 1'b1);
    wait_done(2000);
    @(negedge clk);
    check("n0_len", last_len, 640);
    check("n0_nsamp", last_samp.size(), 10);
    expect_rx(8'h01);
    send(8'h01, 4'd12, 1'b1);
    wait_done(2000);
    @(negedge clk);
    check("n12_len", last_len, 640);
    check("n12_nsamp", last_samp.size(), 10);
    expect_rx(8'h01);

    // tx_start while busy is ignored and not queued.
    d0 = done_cnt;
    send(8'h3C, 4'd8, 1'b1);
    repeat (200) @(posedge clk);
    #2;
    TxD = 8'hFF; N_bits = 4'd5; tx_start = 1'b1;
    @(posedge clk); #2;
    tx_start = 1'b0;
    wait_done(2000);
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("prot_done_cnt", done_cnt, d0 + 1);
    check("prot_busy", busy, 0);
    check("prot_len", last_len, 640);
    expect_rx(8'h3C);
    check("prot_no_extra", rx_q.size(), 0);

    // Back-to-back with tx_start held high.
    @(posedge clk); #2;
    TxD = 8'h55; N_bits = 4'd8; tx_start = 1'b1;
    g = 0;
    while (!busy && g < 20) begin @(negedge clk); g++; end
    check("b2b_accept", busy, 1);
    @(posedge clk); #2;
    TxD = 8'hAA;
    wait_done(2000);
    g = 0;
    while (!busy && g < 20) begin @(negedge clk); g++; end
    check("b2b_second_accept", busy, 1);
    @(posedge clk); #2;
    tx_start = 1'b0;
    wait_done(2000);
    @(negedge clk);
    check("b2b_gap_ticks", last_gap, 160);
    expect_rx(8'h55);
    expect_rx(8'hAA);

    // Reset mid-DATA abandons the frame.
    send(8'hA5, 4'd8, 1'b1);
    repeat (200) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_tx", Tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    d0 = done_cnt;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_tx", Tx, 1);
    check("post_rst_done_cnt", done_cnt, d0);
    check("post_rst_rx", rx_q.size(), 0);

    // Random traffic with random Tick spacing.
    rx_q.delete();
    exp_q.delete();
    tick_period = 0;
    for (int c = 0; c < 8000; c++) begin
      @(posedge clk); #2;
      tx_start = ($urandom_range(0, 40) == 0);
      TxD      = 8'($urandom);
      N_bits   = 4'($urandom);
    end
    @(posedge clk); #2;
    tx_start = 1'b0;
    @(negedge clk);
    g = 0;
    while (busy && g < 5000) begin @(negedge clk); g++; end
    check("rand_idle", busy, 0);
    check("rand_frames", rx_q.size(), exp_q.size());
    while (rx_q.size() != 0 && exp_q.size() != 0)
      check("rand_rx_byte", rx_q.pop_front(), exp_q.pop_front());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_module.md
# tx_module

UART transmitter that serialises one parallel byte into an asynchronous frame: start bit, then N_bits data bits LSB first, then one stop bit. It is the sending-side counterpart of the oversampling receiver. It uses the same 16× baud-rate Tick, so each serial bit lasts exactly 16 Tick pulses. A host loads data with a start/busy handshake, and a one-cycle done pulse marks frame completion.

## Interface
- No parameters; the frame format is fixed at 1 start bit, 1–8 data bits and 1 stop bit, with no parity.
- clk  input  1  system clock; all state changes occur on its rising edge.
- rst  input  1  reset, asynchronous and active-low.
- Tick  input  1  16× baud enable, synchronous to clk, high for one clk cycle per pulse.
- tx_start  input  1  request to send; sampled only in IDLE.
- TxD  input  8  parallel data; captured on acceptance.
- N_bits  input  4  data-bit count; captured on acceptance.
- Tx  output  1  serial line; idles high.
- busy  output  1  high from acceptance until the frame ends.
- done  output  1  one-clk pulse at the end of the frame.

## Operation
- States: IDLE, START, DATA, STOP. The state register is 2 bits.
- Internal registers:
  - shift register, 8 bits
  - tick counter, 4 bits
  - bit counter, 4 bits
  - latched bit count n, 4 bits
- IDLE:
  - Tx=1, busy=0.
  - On a clk edge with tx_start=1, the block latches TxD into the shift register, latches n, clears the tick counter and bit counter, and enters START.
- Bit-count latching:
  - N_bits values 1..8 are latched as given.
  - Values 0 and 9..15 are latched as 8.
- START:
  - Tx=0.
  - Each Tick increments the tick counter.
  - On the Tick where the counter equals 15, the counter wraps to 0 and the state goes to DATA.
- DATA:
  - Tx = shift register bit 0.
  - On the Tick where the counter equals 15: the shift register shifts right by one (zero fill), the bit counter increments, and the counter wraps.
  - When the bit counter reaches n, the state goes to STOP.
- STOP:
  - Tx=1.
  - On the Tick where the counter equals 15, the state goes to IDLE, done=1 for that clk cycle, and busy falls on the same edge.
- TxD and N_bits changes while busy have no effect. tx_start while busy is ignored and not queued.
- Tick is ignored in IDLE. Clk cycles without Tick never advance the counters.
- Asynchronous reset (rst=0) in any state immediately gives:
  - state=IDLE
  - Tx=1, busy=0, done=0
  - all counters 0, shift register 0
- A frame interrupted by reset is abandoned; there is no resume.

## Timing
- Reset values: Tx=1, busy=0, done=0.
- All outputs are registered; Tx has no combinational path from any input.
- Acceptance edge E:
  - At E+1 cycle: busy=1 and Tx=0.
  - The start bit holds for exactly 16 Tick pulses after E. A Tick coincident with edge E is not counted.
- Frame length is (n+2)×16 Tick pulses. At Tick period T clocks, the line is low/data for (n+1)×16×T cycles and the stop bit is high for 16×T cycles.
- End of frame:
  - done is high for exactly one clk cycle, coincident with busy going low.
  - The earliest next acceptance is the edge after done; that edge may accept a new tx_start (back-to-back frames). In that case the stop bit lasts exactly 16 Ticks and is followed by the next start bit with no extra idle.
- Simultaneous tx_start and Tick in IDLE: the request is accepted and the Tick is discarded.

## Test plan
- Reset: hold rst=0 mid-DATA of a frame with TxD=8'hA5, then release → Tx=1, busy=0, done=0 immediately on assertion; no further transitions until a new tx_start.
- Basic byte: N_bits=8, TxD=8'h53, Tick every 4 clk → Tx sequence 0,1,1,0,0,1,0,1,0,1, each bit 64 clk; busy high for 640 clk; one done pulse.
- Short frame: N_bits=5, TxD=8'hFF → start, five 1s, stop; 112 Ticks total; bits 5..7 never appear on Tx.
- Invalid count: N_bits=0 and N_bits=12, TxD=8'h01 → each behaves as an 8-bit frame of 160 Ticks.
- Busy protection: after acceptance of 8'h3C, pulse tx_start with TxD=8'hFF mid-frame → frame still carries 8'h3C; no second frame; single done.
- Back-to-back: tx_start held high, TxD=8'h55 then 8'hAA → second start bit immediately follows the first stop bit of exactly 16 Ticks; two done pulses 160 Ticks apart; loopback into the receiver yields 8'h55 then 8'hAA.
